// File: rtl/dmem_responder.sv
// Word-addressed data memory responder with request/response valid-ready handshakes.
// Define DMEM_STATS_EN to add saturating load/store/error response counters.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic        op_write;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        accept, access, done;
  logic        op_err;
  logic [AW-1:0] op_idx;

  logic [31:0] mem [DEPTH];

  // DEPTH is a power of two, so any set bit above the index field is out of range.
  assign op_err = (op_addr[1:0] != 2'b00) || (op_addr[31:AW+2] != '0);
  assign op_idx = op_addr[AW+1:2];

  // The wait counter is loaded with LATENCY and the access happens on the edge
  // where it reads zero, giving rsp_valid LATENCY+1 edges after acceptance.
  always_comb begin
    state_next = state;
    count_next = count;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          count_next = 4'(LATENCY);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      op_write  <= 1'b0;
      op_addr   <= 32'd0;
      op_wdata  <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        op_write <= req_write;
        op_addr  <= req_addr;
        op_wdata <= req_wdata;
      end
      if (access) begin
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_write) ? 32'd0 : mem[op_idx];
      end else if (done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // Array has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (access && op_write && !op_err)
      mem[op_idx] <= op_wdata;
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
      err_count <= 16'd0;
    end else if (done) begin
      if (rsp_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (op_write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: random and directed loads/stores against
// an array model; a second instance checks the zero-wait-state timing.
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_rsp_ready = 1'b1;
  logic [31:0] b_req_addr = 32'd0, b_req_wdata = 32'd0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
`ifdef DMEM_STATS_EN
  logic [15:0] rd_count, wr_count, err_count;
  logic [15:0] b_rd_count, b_wr_count, b_err_count;
`endif

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
`ifdef DMEM_STATS_EN
    , .rd_count(b_rd_count), .wr_count(b_wr_count), .err_count(b_err_count)
`endif
  );

  typedef struct {
    int          acc;
    bit          w;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          edge_cnt = 0;
  int          rr_mode = 1;  // 0 random, 1 always ready, 2 never ready
  logic [31:0] model_mem [DEPTH];
  int          m_rd = 0, m_wr = 0, m_err = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       rsp_ready = 1'($urandom_range(0, 1));
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      fail_now("issue_wait_ready");
      return;
    end
    e.acc   = edge_cnt + 1;
    e.w     = w;
    e.err   = addr_bad(a);
    e.rdata = (e.err || w) ? 32'd0 : model_mem[a / 4];
    if (w && !e.err) model_mem[a / 4] = d;
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) fail_now("wait_rsp_valid");
  endtask

  task automatic wait_drain();
    int t = 0;
    while (!(exp_q.size() == 0 && req_ready && !rsp_valid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) fail_now("drain");
  endtask

  // Monitor: pops one expectation per response, checks latency, data and stability.
  exp_t        cur;
  bit          cur_ok = 0;
  logic [31:0] snap_d;
  logic        snap_e;
  bit          prev_valid = 0, prev_cons = 0;
  int          n_rsp = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      prev_cons  = 0;
    end else begin
      if (rsp_valid) begin
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (!prev_valid || prev_cons) begin
          if (exp_q.size() == 0) begin
            cur_ok = 0;
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got rdata=%h err=%0d, required no response", rsp_rdata, rsp_err);
          end else begin
            cur    = exp_q.pop_front();
            cur_ok = 1;
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(cur.err));
            chk("latency", edge_cnt, cur.acc + LAT + 1);
            n_rsp++;
            $display("rsp %0d: write=%0d err=%0d rdata=%h", n_rsp, cur.w, rsp_err, rsp_rdata);
          end
          snap_d = rsp_rdata;
          snap_e = rsp_err;
        end else begin
          chk("rdata_stable", rsp_rdata, snap_d);
          chk("err_stable", 32'(rsp_err), 32'(snap_e));
        end
        if (rsp_ready && cur_ok) begin
          if (cur.err) m_err++;
          else if (cur.w) m_wr++;
          else m_rd++;
          cur_ok = 0;
        end
      end
      prev_valid = rsp_valid;
      prev_cons  = rsp_valid && rsp_ready;
    end
  end

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    m_rd = 0; m_wr = 0; m_err = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, d;
    int acc0, t;

    repeat (3) @(negedge clk);
    pulse_reset();
    repeat (2) @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Fill the array so every later load has a defined expected value.
    rr_mode = 0;
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom());
    wait_drain();

    // Directed store/load, misaligned and out-of-range accesses.
    rr_mode = 1;
    issue(1'b1, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 32'd0);
    issue(1'b0, 32'h12, 32'd0);
    issue(1'b0, 32'h100, 32'd0);
    issue(1'b0, 32'h10, 32'd0);
    wait_drain();

    // Backpressure with an ignored store request during the held response.
    rr_mode = 2;
    issue(1'b0, 32'h10, 32'd0);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      if (i == 2) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h14; req_wdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
      @(negedge clk);
    end
    rr_mode = 1;
    wait_drain();
    issue(1'b0, 32'h14, 32'd0);
    wait_drain();

    // Reset while a store is still waiting: the store must be dropped.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    pulse_reset();
    issue(1'b0, 32'h20, 32'd0);
    wait_drain();

    // Reset while a response is held: it must be discarded.
    rr_mode = 2;
    issue(1'b0, 32'h24, 32'd0);
    wait_rsp();
    @(negedge clk);
    pulse_reset();
    rr_mode = 1;
    repeat (2) @(negedge clk);
    chk("after_discard_rsp_valid", 32'(rsp_valid), 32'd0);

    // Random traffic with random response backpressure.
    rr_mode = 0;
    for (int i = 0; i < 150; i++) begin
      t = $urandom_range(0, 9);
      if (t < 8) a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (t == 8) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else a = ($urandom() | 32'h0000_0100) & 32'hFFFF_FFFC;
      d = $urandom();
      issue(1'($urandom_range(0, 1)), a, d);
    end
    rr_mode = 1;
    wait_drain();

`ifdef DMEM_STATS_EN
    repeat (2) @(negedge clk);
    chk("rd_count", 32'(rd_count), 32'(m_rd));
    chk("wr_count", 32'(wr_count), 32'(m_wr));
    chk("err_count", 32'(err_count), 32'(m_err));
    pulse_reset();
    chk("rd_count_rst", 32'(rd_count), 32'd0);
    chk("wr_count_rst", 32'(wr_count), 32'd0);
    chk("err_count_rst", 32'(err_count), 32'd0);
`endif

    // Zero-wait-state instance: store then load, response one edge after acceptance.
    for (int k = 0; k < 2; k++) begin
      chk("lat0_req_ready", 32'(b_req_ready), 32'd1);
      b_req_valid = 1'b1;
      b_req_write = (k == 0);
      b_req_addr  = 32'h8;
      b_req_wdata = 32'hCAFEF00D;
      acc0 = edge_cnt + 1;
      @(posedge clk);
      #1 b_req_valid = 1'b0;
      @(negedge clk);
      t = 0;
      while (!b_rsp_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!b_rsp_valid) fail_now("lat0_wait");
      else begin
        chk("lat0_latency", edge_cnt, acc0 + 1);
        chk("lat0_rdata", b_rsp_rdata, (k == 0) ? 32'd0 : 32'hCAFEF00D);
        chk("lat0_err", 32'(b_rsp_err), 32'd0);
      end
      repeat (2) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
